demux1to4_stream: RTL and testbench
===================================

# demux1to4_stream

- Routes 4-bit words from one upstream source to one of four downstream sinks selected by `Sel`: the inverse of the existing 4x1 selector.
- Each output channel has a one-entry registered slot with valid/ready flow control.
- A burst mode locks the selected channel for a programmable number of beats.
- Sits between a single producer and four per-lane consumers in the datapath.

## Interface

Parameters:
- `WIDTH`, 4: data word width.
- `LEN_W`, 4: width of the burst length field.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `Data_in`, in, WIDTH: upstream word.
- `Sel`, in, 2: target channel, encoded as S0=00 to O0, S1=01 to O1, S2=10 to O2, S3=11 to O3. Sampled only on the first beat of a burst.
- `Burst_len`, in, LEN_W: extra beats after the first; 0 means a single beat. Sampled with `Sel`.
- `In_valid`, in, 1: upstream word valid.
- `In_ready`, out, 1: block can accept the word this cycle.
- `O0`, `O1`, `O2`, `O3`, out, WIDTH each: registered channel data.
- `Out_valid`, out, 4: per-channel valid; bit n corresponds to On.
- `Out_ready`, in, 4: per-channel downstream ready.
- `Busy`, out, 1: high while in BURST.

## Operation

- **Accept:** a beat is accepted when `In_valid & In_ready` at a rising edge.
- **Target channel:** `Sel` in IDLE; the locked channel `sel_q` in BURST.
- **Per-channel slot:** holds flag `full[n]` and data register.
  - Accept to channel n sets `full[n]` and loads `Data_in`.
  - `Out_valid[n] & Out_ready[n]` clears `full[n]`.
  - Simultaneous drain and accept on the same channel: `full[n]` stays 1 and the data register takes the new word. No bubble.
  - `Out_valid[n]` equals `full[n]`.
- **Input ready:** `In_ready = ~full[t] | Out_ready[t]`, where t is the target channel.
  - `In_ready` is combinational from `Out_ready` and `Sel`/`sel_q`.
  - `In_ready` does not depend on `In_valid`.
- **Channel independence:** non-target channels keep their state. Their drains proceed independently in the same cycle.
- **State machine (states IDLE, BURST):**
  - **IDLE:** on accept, `sel_q` <- `Sel` and `rem` <- `Burst_len`.
    - If `Burst_len` = 0, stay in IDLE.
    - Otherwise go to BURST.
  - **BURST:** `Sel` and `Burst_len` are ignored. Each accept decrements `rem`.
    - Accept with `rem` = 1: go to IDLE with `rem` = 0.
    - No accept: hold the state.
- **Burst length:** a burst carries `Burst_len`+1 beats. The maximum is 2^LEN_W beats (16 by default).
- **Data:** words pass unmodified. No width conversion, no arithmetic on data.

## Timing

- **Latency:** a word accepted at edge k appears on On with `Out_valid[n]`=1 after edge k, i.e. one cycle.
- **Throughput:** one word per cycle to a channel whose `Out_ready` is held high. Channel switching between single-beat transfers costs no cycles.
- **Reset:** `rst` high at an edge forces:
  - state IDLE, `rem` 0, `sel_q` 00;
  - `full` = 0000, so `Out_valid` = 0000;
  - O0 to O3 = 0;
  - `Busy` = 0.
  - `In_ready` after reset equals 1, since all slots are empty.
- **Reset mid-burst or with full slots:** held words are discarded, not delivered, and the burst is abandoned.
- **Stall:** when `full[t]` is set and `Out_ready[t]` is low, `In_ready` is 0. The upstream must hold `Data_in`/`Sel`/`Burst_len` stable while `In_valid` is high.
- **Boundaries:**
  - `Burst_len` at its maximum value (all ones) gives 16 beats with no counter wrap.
  - `rem` never underflows; a decrement only occurs in BURST, where `rem` ≥ 1.
- **Busy:** a registered decode of the state, high on the cycle after a first-beat accept with `Burst_len` ≠ 0.

## Structure

- **Package `demux_pkg`:**
  - state enum IDLE/BURST;
  - channel select constants S0..S3;
  - default widths `WIDTH` = 4 and `LEN_W` = 4.
- **Sub-module `demux_slot`:** a one-entry register plus full flag with valid/ready. It is instantiated four times. Ports:
  - `clk`, `rst`, `wr_en`, `wr_data`;
  - `full`, `rd_data`, `rd_ready`.
- **Top level:** the FSM, `rem`/`sel_q` registers, target decode, and the `In_ready` mux.

## Test plan

- **Reset check:** reset, then check the reset values.
  - Drive single beats 0xA to S2 and 0x5 to S0 with all `Out_ready` = 1.
  - Required: O2 = A with `Out_valid` = 0100 on the first cycle, then O0 = 5 with `Out_valid` = 0001. `In_ready` stays 1 throughout.
- **Back-pressure:** `Out_ready[1]` = 0. Send 0x3 to S1, then 0x7 to S1.
  - Required: the second beat stalls with `In_ready` = 0 and O1 holds 3.
  - Required: raising `Out_ready[1]` drains 3 and accepts 7 in the same cycle, and O1 = 7 on the next cycle.
- **Burst lock:** `Sel` = 11 and `Burst_len` = 3 on the first beat, then `Sel` toggling to 00.
  - Required: all 4 beats land on O3, `Busy` is high for 3 cycles, then returns to IDLE.
  - Required: the next beat with `Sel` = 00 goes to O0.
- **Maximum burst:** `Burst_len` = 15.
  - Required: exactly 16 beats are routed to one channel and the 17th beat follows the new `Sel`.
- **Reset mid-burst:** assert `rst` mid-burst with O2 full.
  - Required: the next cycle shows `Out_valid` = 0000, `Busy` = 0, and O2 = 0.
  - Required: a subsequent beat follows the live `Sel`.
- **Channel independence:** O0 stalled and full while beats to S1 stream at full rate.
  - Required: O1 receives one word per cycle and O0 holds its value unchanged.

Source files
------------

// File: rtl/demux1to4_stream_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 4;
  localparam int NUM_CH    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  // One-hot channel decode of a select code.
  function automatic logic [NUM_CH-1:0] chan_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      S0: oh = 4'b0001;
      S1: oh = 4'b0010;
      S2: oh = 4'b0100;
      S3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_stream_if.sv
// Handshake/data bundle between the producer, the demux and four consumers.
interface demux1to4_stream_if #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
);
  logic [WIDTH-1:0] Data_in;
  logic [1:0]       Sel;
  logic [LEN_W-1:0] Burst_len;
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] O0;
  logic [WIDTH-1:0] O1;
  logic [WIDTH-1:0] O2;
  logic [WIDTH-1:0] O3;
  logic [3:0]       Out_valid;
  logic [3:0]       Out_ready;
  logic             Busy;

  // Producer/consumer side.
  modport master (
    output Data_in, Sel, Burst_len, In_valid, Out_ready,
    input  In_ready, O0, O1, O2, O3, Out_valid, Busy
  );

  // Demux side.
  modport slave (
    input  Data_in, Sel, Burst_len, In_valid, Out_ready,
    output In_ready, O0, O1, O2, O3, Out_valid, Busy
  );
endinterface

// File: rtl/demux1to4_stream_slot.sv
// One-entry output slot: data register plus full flag with valid/ready.
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Drain clears, write sets; a write in the same cycle as a drain wins,
  // so a streaming channel never inserts a bubble.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && rd_ready) full_d = 1'b0;
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end
  end

  // Slot state register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full    = full_q;
  assign rd_data = data_q;

endmodule

// File: rtl/demux1to4_stream.sv
// 1-to-4 stream demux: routes each accepted word to the selected channel
// slot, with an optional burst mode that locks the channel for N+1 beats.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  demux1to4_stream_if.slave   bus
);

  state_t                         state_q, state_d;
  logic [1:0]                     sel_q, sel_d;
  logic [LEN_W-1:0]               rem_q, rem_d;
  logic                           busy_q;
  logic [1:0]                     tgt;
  logic                           accept;
  logic [NUM_CH-1:0]              full;
  logic [NUM_CH-1:0]              wr_en;
  logic [NUM_CH-1:0][WIDTH-1:0]   rd_data;

  // Target is the live select between bursts, the locked one inside a burst.
  assign tgt    = (state_q == BURST) ? sel_q : bus.Sel;
  assign bus.In_ready = ~full[tgt] | bus.Out_ready[tgt];
  assign accept = bus.In_valid & bus.In_ready;
  assign wr_en  = accept ? chan_onehot(tgt) : '0;

  // Burst control: latch channel and length on the first beat, count down
  // remaining beats; rem is only decremented while >= 1.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = bus.Sel;
          rem_d = bus.Burst_len;
          if (bus.Burst_len != '0) state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and burst bookkeeping registers; Busy is registered off next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= S0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d == BURST);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[n]),
      .wr_data  (bus.Data_in),
      .full     (full[n]),
      .rd_data  (rd_data[n]),
      .rd_ready (bus.Out_ready[n])
    );
  end

  assign bus.O0        = rd_data[0];
  assign bus.O1        = rd_data[1];
  assign bus.O2        = rd_data[2];
  assign bus.O3        = rd_data[3];
  assign bus.Out_valid = full;
  assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream.
module tb_demux1to4_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  demux1to4_stream_if #(.WIDTH(4), .LEN_W(4)) bus ();

  demux1to4_stream #(.WIDTH(4), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] bl,
                       input logic [3:0] d);
    bus.In_valid  = v;
    bus.Sel       = s;
    bus.Burst_len = bl;
    bus.Data_in   = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    bus.Out_ready = 4'hF;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset values
    chk("rst_ovalid", 32'(bus.Out_valid), 32'h0);
    chk("rst_busy",   32'(bus.Busy),      32'h0);
    chk("rst_o0",     32'(bus.O0),        32'h0);
    chk("rst_o1",     32'(bus.O1),        32'h0);
    chk("rst_o2",     32'(bus.O2),        32'h0);
    chk("rst_o3",     32'(bus.O3),        32'h0);
    chk("rst_inrdy",  32'(bus.In_ready),  32'h1);

    // Single beats: A to S2, then 5 to S0
    drive(1'b1, 2'b10, 4'h0, 4'hA);
    #1 chk("sb_rdy0", 32'(bus.In_ready), 32'h1);
    tick();
    chk("sb_o2",   32'(bus.O2),        32'hA);
    chk("sb_ov2",  32'(bus.Out_valid), 32'b0100);
    drive(1'b1, 2'b00, 4'h0, 4'h5);
    #1 chk("sb_rdy1", 32'(bus.In_ready), 32'h1);
    tick();
    chk("sb_o0",   32'(bus.O0),        32'h5);
    chk("sb_ov0",  32'(bus.Out_valid), 32'b0001);
    chk("sb_rdy2", 32'(bus.In_ready),  32'h1);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    chk("sb_idle", 32'(bus.Out_valid), 32'h0);

    // Back-pressure on channel 1
    bus.Out_ready = 4'b1101;
    drive(1'b1, 2'b01, 4'h0, 4'h3);
    tick();
    chk("bp_o1a",  32'(bus.O1),        32'h3);
    chk("bp_ov1",  32'(bus.Out_valid), 32'b0010);
    drive(1'b1, 2'b01, 4'h0, 4'h7);
    #1 chk("bp_stall", 32'(bus.In_ready), 32'h0);
    tick();
    chk("bp_hold", 32'(bus.O1),        32'h3);
    chk("bp_rdy",  32'(bus.In_ready),  32'h0);
    bus.Out_ready = 4'hF;
    #1 chk("bp_comb_rdy", 32'(bus.In_ready), 32'h1);
    tick();
    chk("bp_o1b",  32'(bus.O1),        32'h7);
    chk("bp_ov1b", 32'(bus.Out_valid), 32'b0010);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    chk("bp_drain", 32'(bus.Out_valid), 32'h0);

    // Burst lock: Sel=3, Burst_len=3, then Sel toggles to 0
    drive(1'b1, 2'b11, 4'h3, 4'h1);
    tick();
    chk("bl_o3_1", 32'(bus.O3),        32'h1);
    chk("bl_busy1", 32'(bus.Busy),     32'h1);
    drive(1'b1, 2'b00, 4'h0, 4'h2);
    tick();
    chk("bl_o3_2", 32'(bus.O3),        32'h2);
    chk("bl_ov_2", 32'(bus.Out_valid), 32'b1000);
    chk("bl_busy2", 32'(bus.Busy),     32'h1);
    drive(1'b1, 2'b00, 4'h0, 4'h3);
    tick();
    chk("bl_o3_3", 32'(bus.O3),        32'h3);
    chk("bl_busy3", 32'(bus.Busy),     32'h1);
    drive(1'b1, 2'b00, 4'h0, 4'h4);
    tick();
    chk("bl_o3_4", 32'(bus.O3),        32'h4);
    chk("bl_ov_4", 32'(bus.Out_valid), 32'b1000);
    chk("bl_busy4", 32'(bus.Busy),     32'h0);
    drive(1'b1, 2'b00, 4'h0, 4'h9);
    tick();
    chk("bl_next_o0", 32'(bus.O0),        32'h9);
    chk("bl_next_ov", 32'(bus.Out_valid), 32'b0001);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();

    // Maximum burst: 16 beats to channel 1, Sel wanders meanwhile
    drive(1'b1, 2'b01, 4'hF, 4'h0);
    tick();
    chk("mx_o1_0", 32'(bus.O1), 32'h0);
    chk("mx_ov_0", 32'(bus.Out_valid), 32'b0010);
    for (int i = 1; i < 16; i++) begin
      drive(1'b1, 2'(i % 4), 4'(16 - i), 4'(i));
      tick();
      chk($sformatf("mx_o1_%0d", i), 32'(bus.O1), 32'(i));
      chk($sformatf("mx_ov_%0d", i), 32'(bus.Out_valid), 32'b0010);
      chk($sformatf("mx_busy_%0d", i), 32'(bus.Busy), (i < 15) ? 32'h1 : 32'h0);
    end
    drive(1'b1, 2'b10, 4'h0, 4'hE);
    tick();
    chk("mx_17_o2", 32'(bus.O2),        32'hE);
    chk("mx_17_ov", 32'(bus.Out_valid), 32'b0100);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();

    // Reset mid-burst with O2 held full
    bus.Out_ready = 4'b1011;
    drive(1'b1, 2'b10, 4'h5, 4'h6);
    tick();
    chk("rb_o2",   32'(bus.O2),        32'h6);
    chk("rb_ov",   32'(bus.Out_valid), 32'b0100);
    chk("rb_busy", 32'(bus.Busy),      32'h1);
    drive(1'b0, 2'b10, 4'h0, 4'h0);
    rst = 1'b1;
    tick();
    chk("rb_ov0",   32'(bus.Out_valid), 32'h0);
    chk("rb_busy0", 32'(bus.Busy),      32'h0);
    chk("rb_o2_0",  32'(bus.O2),        32'h0);
    rst = 1'b0;
    bus.Out_ready = 4'hF;
    drive(1'b1, 2'b00, 4'h0, 4'hB);
    tick();
    chk("rb_live_o0", 32'(bus.O0),        32'hB);
    chk("rb_live_ov", 32'(bus.Out_valid), 32'b0001);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();

    // Channel independence: O0 stalled full, S1 streams every cycle
    bus.Out_ready = 4'b1110;
    drive(1'b1, 2'b00, 4'h0, 4'hC);
    tick();
    chk("ci_o0", 32'(bus.O0), 32'hC);
    for (int d = 1; d <= 4; d++) begin
      drive(1'b1, 2'b01, 4'h0, 4'(d));
      #1 chk($sformatf("ci_rdy_%0d", d), 32'(bus.In_ready), 32'h1);
      tick();
      chk($sformatf("ci_o1_%0d", d), 32'(bus.O1), 32'(d));
      chk($sformatf("ci_ov_%0d", d), 32'(bus.Out_valid), 32'b0011);
      chk($sformatf("ci_o0h_%0d", d), 32'(bus.O0), 32'hC);
    end
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    tick();
    chk("ci_end_ov", 32'(bus.Out_valid), 32'b0001);
    chk("ci_end_o0", 32'(bus.O0),        32'hC);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
